// File: rtl/maze_pkg.sv
// Shared maze definitions: move codes, default coordinate width, replayer state encoding.
package maze_pkg;

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    localparam int MAZE_CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECORD = 3'd1,
        ST_READY  = 3'd2,
        ST_REPLAY = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAILED = 3'd5
    } replay_state_t;

endpackage

// File: rtl/path_stack_mem.sv
// Move storage for the replayer: synchronous write, asynchronous read.
module path_stack_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maze_path_replayer.sv
// Records the solver's committed moves as a stack and replays the surviving path
// from the entrance, one move per cycle with running row/col.
//
// state     | meaning
// ST_IDLE   | after reset, waiting for start
// ST_RECORD | tracking solver push/pop
// ST_READY  | solver succeeded, waiting for run
// ST_REPLAY | emitting stored moves in order
// ST_DONE   | replay finished, run replays again
// ST_FAILED | solver failed, locked until start
module maze_path_replayer
    import maze_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int CW    = MAZE_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    move_in,
    input  logic          solved,
    input  logic          fail,
    input  logic          run,
    output logic [1:0]    move_out,
    output logic          move_valid,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW:0]   path_len,
    output logic          replay_done,
    output logic          overflow,
    output logic          locked
);

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    replay_state_t state, state_nx;

    logic [AW:0]   sp, sp_nx, idx;
    logic          emit, finish, rep_start, ovf_set;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [1:0]    rd_data;
    logic [CW-1:0] row_nx, col_nx;

    path_stack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (move_in),
        .raddr (idx[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_RECORD;
        end else begin
            case (state)
                ST_IDLE:   state_nx = ST_IDLE;
                ST_RECORD: begin
                    if (fail)        state_nx = ST_FAILED;
                    else if (solved) state_nx = ST_READY;
                end
                ST_READY,
                ST_DONE:   if (run) state_nx = ST_REPLAY;
                ST_REPLAY: if (idx == sp) state_nx = ST_DONE;
                ST_FAILED: state_nx = ST_FAILED;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        finish    = 1'b0;
        rep_start = 1'b0;
        ovf_set   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = sp[AW-1:0];
        sp_nx     = sp;
        if (!start) begin
            case (state)
                ST_RECORD: begin
                    // Simultaneous push/pop replaces the top; on an empty stack it degrades to a push.
                    if (push && pop && sp != '0) begin
                        mem_we    = 1'b1;
                        mem_waddr = sp[AW-1:0] - AW'(1);
                    end else if (push && sp != FULL) begin
                        mem_we = 1'b1;
                        sp_nx  = sp + LEN_ONE;
                    end else if (push) begin
                        ovf_set = 1'b1;
                    end else if (pop && sp != '0) begin
                        sp_nx = sp - LEN_ONE;
                    end
                end
                ST_READY,
                ST_DONE:   rep_start = run;
                ST_REPLAY: begin
                    emit   = (idx != sp);
                    finish = (idx == sp);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        row_nx = row;
        col_nx = col;
        case (rd_data)
            MV_UP:    row_nx = row - CW'(1);
            MV_RIGHT: col_nx = col + CW'(1);
            MV_LEFT:  col_nx = col - CW'(1);
            default:  row_nx = row + CW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= '0;
            idx         <= '0;
            overflow    <= 1'b0;
            move_out    <= '0;
            move_valid  <= 1'b0;
            row         <= '0;
            col         <= '0;
            replay_done <= 1'b0;
        end else begin
            move_valid  <= emit;
            replay_done <= finish;
            if (start) begin
                sp       <= '0;
                idx      <= '0;
                overflow <= 1'b0;
                row      <= '0;
                col      <= '0;
            end else begin
                sp <= sp_nx;
                if (ovf_set) overflow <= 1'b1;
                if (rep_start) begin
                    idx <= '0;
                    row <= '0;
                    col <= '0;
                end
                if (emit) begin
                    move_out <= rd_data;
                    row      <= row_nx;
                    col      <= col_nx;
                    idx      <= idx + LEN_ONE;
                end
            end
        end
    end

    assign path_len = sp;
    assign locked   = (state == ST_FAILED);

endmodule

// File: tb/tb_maze_path_replayer.sv
// Self-checking bench: per-cycle comparison against a queue-based path model,
// plus literal expectations for the directed scenarios.
module tb_maze_path_replayer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, push = 1'b0, pop = 1'b0, solved = 1'b0, fail = 1'b0, run = 1'b0;
    logic [1:0] move_in = 2'b00;
    logic [1:0] move_out;
    logic       move_valid, replay_done, overflow, locked;
    logic [3:0] row, col;
    logic [8:0] path_len;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    maze_path_replayer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .push        (push),
        .pop         (pop),
        .move_in     (move_in),
        .solved      (solved),
        .fail        (fail),
        .run         (run),
        .move_out    (move_out),
        .move_valid  (move_valid),
        .row         (row),
        .col         (col),
        .path_len    (path_len),
        .replay_done (replay_done),
        .overflow    (overflow),
        .locked      (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: stack as a queue; a replay precomputes the whole trajectory from (0,0).
    localparam int M_IDLE = 0, M_REC = 1, M_READY = 2, M_REPLAY = 3, M_DONE = 4, M_FAIL = 5;
    int         mode = M_IDLE;
    logic [1:0] stk [$];
    logic [9:0] traj [$];
    logic       e_valid = 0, e_done = 0, e_ovf = 0;
    logic [1:0] e_move = 0;
    logic [3:0] e_row = 0, e_col = 0;

    always @(posedge clk) begin
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (rst) begin
            mode = M_IDLE;
            stk.delete();
            traj.delete();
            e_ovf = 0; e_move = 0; e_row = 0; e_col = 0;
        end else if (start) begin
            mode = M_REC;
            stk.delete();
            traj.delete();
            e_ovf = 0; e_row = 0; e_col = 0;
        end else begin
            case (mode)
                M_REC: begin
                    if (push && pop && stk.size() > 0) stk[stk.size()-1] = move_in;
                    else if (push && stk.size() < 256) stk.push_back(move_in);
                    else if (push) e_ovf = 1'b1;
                    else if (pop && stk.size() > 0) void'(stk.pop_back());
                    if (fail) mode = M_FAIL;
                    else if (solved) mode = M_READY;
                end
                M_READY, M_DONE: begin
                    if (run) begin
                        int r, c;
                        r = 0; c = 0;
                        traj.delete();
                        foreach (stk[i]) begin
                            case (stk[i])
                                2'd0: r = (r + 15) % 16;
                                2'd1: c = (c + 1) % 16;
                                2'd2: c = (c + 15) % 16;
                                default: r = (r + 1) % 16;
                            endcase
                            traj.push_back({stk[i], 4'(r), 4'(c)});
                        end
                        e_row = 0; e_col = 0;
                        mode = M_REPLAY;
                    end
                end
                M_REPLAY: begin
                    if (traj.size() > 0) begin
                        logic [9:0] t;
                        t = traj.pop_front();
                        e_valid = 1'b1;
                        {e_move, e_row, e_col} = t;
                    end else begin
                        e_done = 1'b1;
                        mode = M_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle_outputs",
                  {move_valid, move_out, row, col, path_len, replay_done, overflow, locked},
                  {e_valid, e_move, e_row, e_col, 9'(stk.size()), e_done, e_ovf, (mode == M_FAIL)});
    end

    logic [9:0] obs [$];
    always @(negedge clk) begin
        if (move_valid) obs.push_back({move_out, row, col});
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_push(input logic [1:0] m);
        push = 1'b1; move_in = m; step(); push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1; step(); pop = 1'b0;
    endtask

    task automatic do_pushpop(input logic [1:0] m);
        push = 1'b1; pop = 1'b1; move_in = m; step(); push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_solved();
        solved = 1'b1; step(); solved = 1'b0;
    endtask

    task automatic do_run();
        obs.delete();
        run = 1'b1; step(); run = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!replay_done && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!replay_done) begin
            errors++;
            $display("FAIL replay_done_timeout actual=0 expected=1 after %0d cycles", n);
        end
    endtask

    initial begin
        int n;
        logic [9:0] first_obs [$];

        step(); step();
        chk_en = 1'b1;
        check("reset_outputs",
              {move_valid, move_out, row, col, path_len, replay_done, overflow, locked}, 0);
        rst = 1'b0;
        step();

        // Scenario 1: right, right, down, down.
        do_start();
        do_push(2'b01); do_push(2'b01); do_push(2'b11); do_push(2'b11);
        do_solved();
        check("s1_path_len", path_len, 4);
        do_run();
        wait_done(20, n);
        check("s1_done_cycle", n, 5);
        check("s1_count", obs.size(), 4);
        if (obs.size() == 4) begin
            check("s1_m0", obs[0], 10'b01_0000_0001);
            check("s1_m1", obs[1], 10'b01_0000_0010);
            check("s1_m2", obs[2], 10'b11_0001_0010);
            check("s1_m3", obs[3], 10'b11_0010_0010);
        end
        first_obs = obs;
        do_push(2'b00);
        check("s1_push_in_done", path_len, 4);
        do_run();
        wait_done(20, n);
        check("s1_rerun_same", (obs == first_obs), 1);

        // Scenario 2: backtracking, replace-top; run held into REPLAY is ignored.
        do_start();
        do_push(2'b01); do_push(2'b11); do_push(2'b01);
        do_pop();
        do_pushpop(2'b11);
        do_solved();
        check("s2_path_len", path_len, 2);
        obs.delete();
        run = 1'b1; step(); step(); run = 1'b0;
        wait_done(20, n);
        check("s2_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("s2_m0", obs[0], 10'b01_0000_0001);
            check("s2_m1", obs[1], 10'b11_0001_0001);
        end

        // Scenario 3: fail locks; fail beats solved.
        do_start();
        do_push(2'b01);
        fail = 1'b1; step(); fail = 1'b0;
        check("s3_locked", locked, 1);
        do_run();
        repeat (4) step();
        check("s3_no_moves", obs.size(), 0);
        do_start();
        check("s3_unlocked", locked, 0);
        check("s3_len_clear", path_len, 0);
        solved = 1'b1; fail = 1'b1; step(); solved = 1'b0; fail = 1'b0;
        check("s3_fail_wins", locked, 1);

        // Scenario 4: empty-stack corner cases, then zero-length replay.
        do_start();
        do_pop();
        check("s4_pop_empty", path_len, 0);
        do_pushpop(2'b10);
        check("s4_pushpop_empty", path_len, 1);
        do_pop();
        do_solved();
        do_run();
        wait_done(10, n);
        check("s4_zero_len_moves", obs.size(), 0);

        // Scenario 5: overflow at full depth.
        do_start();
        for (int i = 0; i < 257; i++) do_push(2'(i % 4));
        check("s5_len_full", path_len, 256);
        check("s5_overflow", overflow, 1);
        do_solved();
        do_run();
        wait_done(300, n);
        check("s5_count", obs.size(), 256);
        do_start();
        check("s5_ovf_cleared", overflow, 0);

        // Scenario 6: wrap-around going up from the origin.
        do_push(2'b00);
        do_solved();
        do_run();
        wait_done(10, n);
        check("s6_count", obs.size(), 1);
        if (obs.size() == 1) check("s6_wrap", obs[0], 10'b00_1111_0000);

        // Scenario 7: start aborts a replay.
        do_start();
        do_push(2'b01); do_push(2'b01); do_push(2'b01);
        do_solved();
        do_run();
        step();
        do_start();
        check("s7_abort_valid", move_valid, 0);
        check("s7_abort_len", path_len, 0);

        // Scenario 8: reset on the second replay cycle.
        do_push(2'b01); do_push(2'b01); do_push(2'b11);
        do_solved();
        do_run();
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("s8_rst_outputs", {move_valid, row, col, path_len, locked}, 0);
        do_run();
        repeat (5) step();
        check("s8_run_after_rst", obs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/maze_path_replayer.md
# maze_path_replayer

Downstream consumer of the `rat_in_maze` solver. While the solver explores the maze, this block records its committed moves as a stack: push on advance, pop on backtrack. Once the solver reports success, a `run` pulse replays the surviving path from the entrance. The replay emits one move per cycle, together with the rat's running row/column, for display or actuator logic. A solver failure locks the block until the next `start`.

## Interface

Parameters:
- `DEPTH`, 256, maximum number of stored moves.
- `AW`, 8, address/length width; `DEPTH` = 2^`AW`.
- `CW`, 4, coordinate width; the maze is 2^`CW` × 2^`CW`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  clears the stack and enters RECORD. Shared with the solver's `start`.
- `push`  in  1  records `move_in` on top of the stack.
- `pop`  in  1  removes the top entry (solver backtrack).
- `move_in`  in  2  move code.
- `solved`  in  1  solver `done`.
- `fail`  in  1  solver `fail`.
- `run`  in  1  replay request.
- `move_out`  out  2  replayed move code.
- `move_valid`  out  1  `move_out`, `row` and `col` are valid this cycle.
- `row`, `col`  out  `CW`  position after applying `move_out`.
- `path_len`  out  `AW`+1  current stack depth.
- `replay_done`  out  1  one-cycle pulse after the last move.
- `overflow`  out  1  sticky; a push was attempted while full.
- `locked`  out  1  high in FAILED.

## Operation

- Move codes: 00 up (row−1), 01 right (col+1), 10 left (col−1), 11 down (row+1). Coordinates wrap modulo 2^`CW`.
- States:
  - IDLE: `start` → RECORD.
  - RECORD: `solved` → READY; `fail` → FAILED. If both are high, FAILED wins.
  - READY: `run` → REPLAY.
  - REPLAY: after the last index → DONE.
  - DONE: `run` → REPLAY again, identical output.
  - FAILED: `run` ignored.
- `start` in any state forces RECORD, clears the stack pointer and `overflow`, and zeroes `row`/`col`.
- RECORD stack rules:
  - `push` alone: write at `sp`, then `sp`+1.
  - `pop` alone: `sp`−1.
  - `push` and `pop` together: overwrite `sp`−1 and leave `sp` unchanged; on an empty stack this acts as a plain push.
  - `pop` on empty: ignored.
  - `push` on full (`sp`=`DEPTH`): ignored and sets `overflow`.
- `push`/`pop` outside RECORD are ignored.
- REPLAY reads indices 0 … `path_len`−1 in order (FIFO order over the stack contents). `row`/`col` restart at 0,0 at every replay start.
- `path_len` is 0 in READY: `run` goes straight to DONE and pulses `replay_done` with no `move_valid`.

## Timing

- Reset values: all outputs 0, state IDLE, `sp`=0.
- `path_len` updates the cycle after each `push`/`pop` edge.
- Replay latency: `run` sampled high at edge N gives the first `move_valid` at edge N+1, then one move per cycle with no gaps.
  - `row`/`col` are registered together with `move_out` and reflect that move already applied.
  - `replay_done` is asserted the cycle after the last `move_valid`.
  - `move_valid` is low in all other states.
- `run` during REPLAY is ignored.
- `rst` mid-replay: the next cycle returns all outputs to reset values and the stack contents are discarded.
- `start` mid-replay: aborts the replay, `move_valid` drops the next cycle.

## Structure

- Shared package `maze_pkg`:
  - move-code constants `MV_UP`/`MV_RIGHT`/`MV_LEFT`/`MV_DOWN`.
  - state encoding for this block.
  - `CW` default, shared with the solver.
- One sub-module `path_stack_mem`: a `DEPTH`×2 register array with synchronous write and asynchronous read.
- The FSM, stack pointer, replay index and coordinate update live in `maze_path_replayer`.

## Test plan

- `start`, push 01,01,11,11, `solved`, `run` → `move_valid` for 4 cycles:
  - moves 01,01,11,11
  - (row,col) = (0,1),(0,2),(1,2),(2,2)
  - `replay_done` on the 5th cycle.
- Push 01,11,01, pop, push 11 together with pop, `solved`, `run` → `path_len`=2; moves 01,11; final (1,1).
- `fail` during RECORD → `locked`=1; `run` gives no `move_valid`; `start` clears `locked` and sets `path_len`=0.
- Push 257 times with `DEPTH`=256 → `path_len`=256, `overflow`=1; `solved`, `run` → exactly 256 moves.
- Record 00 (up) from 0,0 → replay shows row=15, col=0 (wrap-around).
- `rst` on the 2nd replay cycle → the next cycle has `move_valid`=0, `path_len`=0, row/col=0, state IDLE; a subsequent `run` has no effect.
